bb_run_sequencer: RTL and testbench
===================================

# bb_run_sequencer

Run controller for one busy-beaver tape core. It sequences each run: tape clear, core release, stepping under a step budget, then result capture. It sits between the board top level (start/abort, result readout to the display) and a single busy-beaver core. The core's tape RAM accepts a clear-mode write port, and the core advances one step per cycle only while enabled.

## Interface
- TAPE_BITS, 8, tape address width; clear sweep length is 2^TAPE_BITS cycles
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins a run (honoured in IDLE and DONE only)
- abort  in  1  single-cycle pulse; ends the current run (ignored in IDLE/DONE)
- max_steps  in  64  step budget, latched on accepted start; 0 = unlimited
- core_rst_n  out  1  core state/head reset, active-low; low except in ARM/RUN
- clr_en  out  1  core tape write forced to 0 at clr_addr
- clr_addr  out  TAPE_BITS  tape address during clear
- run_en  out  1  core performs one step per cycle while high
- core_halt  in  1  core sticky halt flag (registered in core)
- busy  out  1  high in CLEAR/ARM/RUN
- done  out  1  high in DONE
- status  out  2  00 none, 01 halted, 10 timeout, 11 aborted
- result_steps  out  64  run_en cycles counted for the last run

## Operation
- States: IDLE, CLEAR, ARM, RUN, DONE. All outputs are Moore decodes of registered state/counters.
- IDLE: core_rst_n=0, all else 0. start → CLEAR; latch max_steps; clr_addr←0; status←00; result_steps←0.
- CLEAR: clr_en=1. clr_addr increments each cycle. The edge with clr_addr=all-ones → ARM, clr_addr←0. abort → DONE, status 11.
- ARM: one cycle. core_rst_n=1, run_en=0, step_cnt←0 → RUN. abort → DONE, status 11.
- RUN: run_en=1, core_rst_n=1. Each edge is evaluated in priority order:
  - core_halt=1 → DONE, status 01, result_steps←step_cnt, no increment.
  - else abort → DONE, status 11, result_steps←step_cnt.
  - else step_cnt←step_cnt+1. If max_steps≠0 and step_cnt+1==max_steps → DONE, status 10, result_steps←max_steps.
- DONE: done=1, core_rst_n=0. status and result_steps are held. start → CLEAR (same actions as from IDLE).
- step_cnt is 64-bit and wraps silently at 2^64−1 in unlimited mode. Wrap is not expected in practice.
- start arriving while busy is ignored. start and abort in the same cycle from IDLE/DONE: start wins, abort ignored.

## Timing
- Reset: state IDLE; busy=0, done=0, status=00, result_steps=0, run_en=0, clr_en=0, clr_addr=0, core_rst_n=0. rst_n low mid-run → IDLE on that edge, with no result captured.
- Start to first run_en cycle: 1 (IDLE→CLEAR edge) + 2^TAPE_BITS (CLEAR) + 1 (ARM) edges. For TAPE_BITS=8, run_en first rises 258 cycles after the start edge.
- Timeout: exactly max_steps cycles with run_en=1; done rises on the edge after the last counted cycle.
- Halt: the core raises core_halt one cycle after its halting step, so that step is counted. The cycle in which core_halt is sampled high is not counted. done rises the next cycle.
- Abort latency: one edge from any busy state.

## Test plan
- Reset with rst_n=0 for 3 cycles → all outputs at reset values; core_rst_n=0.
- TAPE_BITS=4, start, core_halt stub never asserts, max_steps=5 → clr_en high 16 cycles sweeping 0..15, then 1 ARM cycle, run_en high exactly 5 cycles; then done=1, status=10, result_steps=5.
- Stub asserts core_halt after run_en has been high 6 cycles, max_steps=0 → status=01, result_steps=6, run_en low the cycle after halt is seen.
- abort during CLEAR at clr_addr=7 → DONE next edge, status=11, run_en never high; next start re-clears from address 0 with status reset to 00.
- core_halt and abort in the same RUN cycle, with the budget expiring on that same edge → status=01 (halt priority).
- rst_n low mid-RUN at step 100 → IDLE, result_steps=0, status=00. start during RUN is ignored, and step count is unaffected.

Source files
------------

// File: rtl/bb_run_sequencer.sv
// bb_run_sequencer: run controller for one busy-beaver tape core.
// Sequences each run: tape clear sweep, core release (one ARM cycle),
// stepping under a 64-bit step budget, then result capture and hold.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        single-cycle control pulses from the board top level
//   max_steps           step budget latched on accepted start (0 = unlimited)
//   core_rst_n          core state/head reset, released only in ARM/RUN
//   clr_en, clr_addr    tape clear-mode write port (writes 0 at clr_addr)
//   run_en              core steps once per cycle while high
//   core_halt           sticky halt flag from the core
//   busy, done          run in progress / result valid
//   status              00 none, 01 halted, 10 timeout, 11 aborted
//   result_steps        run_en cycles counted for the last run
module bb_run_sequencer #(
  parameter int unsigned TAPE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [63:0]          max_steps,
  output logic                 core_rst_n,
  output logic                 clr_en,
  output logic [TAPE_BITS-1:0] clr_addr,
  output logic                 run_en,
  input  logic                 core_halt,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [63:0]          result_steps
);

  localparam int unsigned STEP_W = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_HALTED  = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_ABORTED = 2'b11;

  logic [2:0]           state_q, state_d;
  logic [TAPE_BITS-1:0] clr_addr_d;
  logic [STEP_W-1:0]    max_q, max_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [STEP_W-1:0]    step_inc;
  logic [1:0]           status_d;
  logic [STEP_W-1:0]    result_d;
  logic                 core_rst_n_d, clr_en_d, run_en_d, busy_d, done_d;

  // State and output registers; outputs are decoded from the next state so
  // they line up with the registered state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_addr     <= '0;
      max_q        <= '0;
      step_q       <= '0;
      status       <= STAT_NONE;
      result_steps <= '0;
      core_rst_n   <= 1'b0;
      clr_en       <= 1'b0;
      run_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr     <= clr_addr_d;
      max_q        <= max_d;
      step_q       <= step_d;
      status       <= status_d;
      result_steps <= result_d;
      core_rst_n   <= core_rst_n_d;
      clr_en       <= clr_en_d;
      run_en       <= run_en_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr;
    max_d      = max_q;
    step_d     = step_q;
    status_d   = status;
    result_d   = result_steps;
    step_inc   = step_q + STEP_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start wins over a simultaneous abort here
        if (start) begin
          state_d    = ST_CLEAR;
          max_d      = max_steps;
          clr_addr_d = '0;
          status_d   = STAT_NONE;
          result_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d    = ST_DONE;
          status_d   = STAT_ABORTED;
          clr_addr_d = '0;
        end else if (clr_addr == {TAPE_BITS{1'b1}}) begin
          state_d    = ST_ARM;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr + TAPE_BITS'(1);
        end
      end
      ST_ARM: begin
        step_d = '0;
        if (abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // The cycle in which halt is seen is not a counted step.
        if (core_halt) begin
          state_d  = ST_DONE;
          status_d = STAT_HALTED;
          result_d = step_q;
        end else if (abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
          result_d = step_q;
        end else begin
          step_d = step_inc;
          if ((max_q != '0) && (step_inc == max_q)) begin
            state_d  = ST_DONE;
            status_d = STAT_TIMEOUT;
            result_d = max_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_rst_n_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    clr_en_d     = (state_d == ST_CLEAR);
    run_en_d     = (state_d == ST_RUN);
    busy_d       = (state_d == ST_CLEAR) || (state_d == ST_ARM) || (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_bb_run_sequencer.sv
// Testbench for bb_run_sequencer with a small sticky-halt core stub.
// Expected run results are queued when a run is started and compared
// when done rises.
module tb_bb_run_sequencer;

  localparam int unsigned TB_TAPE_BITS = 4;
  localparam int unsigned BUDGET       = 400;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic [63:0]             max_steps = '0;
  logic                    core_rst_n;
  logic                    clr_en;
  logic [TB_TAPE_BITS-1:0] clr_addr;
  logic                    run_en;
  logic                    core_halt = 1'b0;
  logic                    busy;
  logic                    done;
  logic [1:0]              status;
  logic [63:0]             result_steps;

  typedef struct packed {
    logic [1:0]  status;
    logic [63:0] steps;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   halt_after = 0;
  int   stub_cnt = 0;

  bb_run_sequencer #(.TAPE_BITS(TB_TAPE_BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .max_steps    (max_steps),
    .core_rst_n   (core_rst_n),
    .clr_en       (clr_en),
    .clr_addr     (clr_addr),
    .run_en       (run_en),
    .core_halt    (core_halt),
    .busy         (busy),
    .done         (done),
    .status       (status),
    .result_steps (result_steps)
  );

  always #5 clk = ~clk;

  // Core stub: raises a sticky halt on the edge of its halt_after-th step.
  always @(posedge clk) begin
    if (core_rst_n !== 1'b1) begin
      stub_cnt  <= 0;
      core_halt <= 1'b0;
    end else if (run_en) begin
      stub_cnt <= stub_cnt + 1;
      if (halt_after != 0 && stub_cnt + 1 == halt_after) core_halt <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Starts a run, monitors it cycle by cycle, injects abort/start/reset at
  // chosen points, then checks the captured result against the scoreboard.
  task automatic run_test(input string tag, input logic [63:0] ms, input int halt_n,
                          input bit abort_with_start, input int abort_addr,
                          input int abort_run, input int start_run, input int rst_run,
                          input bit expect_done, input logic [1:0] exp_status,
                          input logic [63:0] exp_steps, input int exp_clr,
                          input int exp_run, input int exp_arm);
    int   clr_cycles = 0;
    int   run_cycles = 0;
    int   arm_cycles = 0;
    int   first_run  = 0;
    int   addr_err   = 0;
    bit   seen_done  = 0;
    bit   rst_pend   = 0;
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    abort      = abort_with_start;
    max_steps  = ms;
    halt_after = halt_n;
    if (expect_done) sb_q.push_back('{status: exp_status, steps: exp_steps});
    for (int cyc = 1; cyc <= int'(BUDGET); cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      if (rst_pend) break;
      if (cyc == 1) begin
        check({tag, "_status_cleared"}, 64'(status), 64'd0);
        check({tag, "_result_cleared"}, result_steps, 64'd0);
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      if (clr_en) begin
        if (clr_addr !== TB_TAPE_BITS'(clr_cycles)) addr_err++;
        clr_cycles++;
      end
      if (run_en) begin
        run_cycles++;
        if (first_run == 0) first_run = cyc;
      end
      if (busy && !clr_en && !run_en) arm_cycles++;
      if (clr_en && int'(clr_addr) == abort_addr) abort = 1'b1;
      if (run_en && run_cycles == abort_run) abort = 1'b1;
      if (run_en && run_cycles == start_run) start = 1'b1;
      if (run_en && run_cycles == rst_run) begin
        rst_n    = 1'b0;
        rst_pend = 1;
      end
    end
    check({tag, "_clr_seq"}, 64'(addr_err), 64'd0);
    if (rst_pend) begin
      check({tag, "_rst_busy"}, 64'(busy), 64'd0);
      check({tag, "_rst_done"}, 64'(done), 64'd0);
      check({tag, "_rst_run_en"}, 64'(run_en), 64'd0);
      check({tag, "_rst_core_rst_n"}, 64'(core_rst_n), 64'd0);
      check({tag, "_rst_status"}, 64'(status), 64'd0);
      check({tag, "_rst_result"}, result_steps, 64'd0);
      check({tag, "_rst_run_cycles"}, 64'(run_cycles), 64'(exp_run));
    end else if (!seen_done) begin
      check({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
        e = sb_q.pop_front();
        check({tag, "_status"}, 64'(status), 64'(e.status));
        check({tag, "_result"}, result_steps, e.steps);
      end
      check({tag, "_busy_low"}, 64'(busy), 64'd0);
      check({tag, "_run_en_low"}, 64'(run_en), 64'd0);
      check({tag, "_core_rst_n_low"}, 64'(core_rst_n), 64'd0);
      check({tag, "_clr_cycles"}, 64'(clr_cycles), 64'(exp_clr));
      check({tag, "_run_cycles"}, 64'(run_cycles), 64'(exp_run));
      check({tag, "_arm_cycles"}, 64'(arm_cycles), 64'(exp_arm));
      if (exp_run > 0) check({tag, "_first_run"}, 64'(first_run), 64'(exp_clr + 2));
    end
  endtask

  initial begin
    // Reset held for three cycles, outputs sampled while still in reset.
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_status", 64'(status), 64'd0);
    check("reset_result", result_steps, 64'd0);
    check("reset_run_en", 64'(run_en), 64'd0);
    check("reset_clr_en", 64'(clr_en), 64'd0);
    check("reset_clr_addr", 64'(clr_addr), 64'd0);
    check("reset_core_rst_n", 64'(core_rst_n), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_core_rst_n", 64'(core_rst_n), 64'd0);

    //        tag        ms  halt aws a_addr a_run s_run r_run exp st     steps clr run arm
    run_test("timeout",  5,  0,   0,  -1,    -1,   -1,   -1,   1,  2'b10, 5,    16, 5,  1);
    run_test("halt",     0,  6,   0,  -1,    -1,   -1,   -1,   1,  2'b01, 6,    16, 7,  1);
    run_test("abort_clr",9,  0,   0,  7,     -1,   -1,   -1,   1,  2'b11, 0,    8,  0,  0);
    run_test("restart",  3,  0,   1,  -1,    -1,   -1,   -1,   1,  2'b10, 3,    16, 3,  1);
    run_test("halt_prio",6,  5,   0,  -1,    6,    -1,   -1,   1,  2'b01, 5,    16, 6,  1);
    run_test("start_ign",20, 0,   0,  -1,    -1,   10,   -1,   1,  2'b10, 20,   16, 20, 1);
    run_test("rst_mid",  0,  0,   0,  -1,    -1,   -1,   100,  0,  2'b00, 0,    16, 100,1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
